// File: rtl/alu_rf_sequencer_if.sv
// alu_rf_sequencer_if
//   Bundles the command handshake, the ALU/register-file control and capture
//   signals, and the done/status outputs of alu_rf_sequencer.
//   slave  : sequencer view (accepts commands, drives the datapath controls)
//   master : front-end/datapath view (issues commands, returns result/flagreg)
// Signals
//   cmd_valid/cmd_ready   command handshake
//   cmd_op/ra1/ra2/wb     command payload
//   regwrite/ra1/ra2/inst register-file and ALU controls
//   result/flagreg        combinational ALU outputs fed back for capture
//   done_valid/result/flags  completion pulse and captured values
//   busy/occupancy        status
interface alu_rf_sequencer_if #(
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [3:0]    cmd_ra1;
  logic [3:0]    cmd_ra2;
  logic          cmd_wb;
  logic          regwrite;
  logic [3:0]    ra1;
  logic [3:0]    ra2;
  logic [3:0]    inst;
  logic [15:0]   result;
  logic [15:0]   flagreg;
  logic          done_valid;
  logic [15:0]   done_result;
  logic [15:0]   done_flags;
  logic          busy;
  logic [AW:0]   occupancy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra1, cmd_ra2, cmd_wb, result, flagreg,
    output cmd_ready, regwrite, ra1, ra2, inst,
           done_valid, done_result, done_flags, busy, occupancy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ra1, cmd_ra2, cmd_wb, result, flagreg,
    input  cmd_ready, regwrite, ra1, ra2, inst,
           done_valid, done_result, done_flags, busy, occupancy
  );
endinterface

// File: rtl/alu_rf_sequencer.sv
// alu_rf_sequencer
//   Command-queued controller for the ALU + register-file pair. Commands
//   (opcode, two register addresses, write-back flag) are buffered in a
//   DEPTH-entry FIFO and sequenced IDLE -> EXEC -> WB -> DONE. The ALU result
//   and flags are captured at the end of EXEC, before any write-back, and
//   returned with a one-cycle done_valid pulse.
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset, clears all state
//   bus    alu_rf_sequencer_if.slave: command handshake, datapath controls,
//          captured results and status
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   AW     log2(DEPTH)
module alu_rf_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic               clk,
  input logic               reset,
  alu_rf_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, DONE} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       wb;
  } cmd_t;

  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rdy_en_q;

  state_t        state_q;
  logic          wb_q;
  logic [3:0]    ra1_q, ra2_q, inst_q;
  logic          regwrite_q;
  logic          done_valid_q;
  logic [15:0]   done_result_q, done_flags_q;

  logic          full, empty, push, pop;
  cmd_t          in_cmd, head;

  assign in_cmd = {bus.cmd_op, bus.cmd_ra1, bus.cmd_ra2, bus.cmd_wb};
  assign head   = fifo_q[rd_ptr_q];
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);

  // rdy_en_q holds cmd_ready low until the first edge after reset releases.
  assign bus.cmd_ready = rdy_en_q & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  // The FSM only takes a new command from IDLE or DONE.
  assign pop           = ~empty & ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Sequencing FSM; every datapath control is a registered output so that no
  // combinational path exists from cmd_* to the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wb_q          <= 1'b0;
      ra1_q         <= '0;
      ra2_q         <= '0;
      inst_q        <= '0;
      regwrite_q    <= 1'b0;
      done_valid_q  <= 1'b0;
      done_result_q <= '0;
      done_flags_q  <= '0;
    end else begin
      regwrite_q   <= 1'b0;
      done_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (pop) begin
            ra1_q   <= head.ra1;
            ra2_q   <= head.ra2;
            inst_q  <= head.op;
            wb_q    <= head.wb;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          // Capture before the write-back so done_result is the pre-write value.
          done_result_q <= bus.result;
          done_flags_q  <= bus.flagreg;
          regwrite_q    <= wb_q;
          state_q       <= WB;
        end
        WB: begin
          ra1_q        <= '0;
          ra2_q        <= '0;
          inst_q       <= '0;
          done_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.regwrite    = regwrite_q;
  assign bus.ra1         = ra1_q;
  assign bus.ra2         = ra2_q;
  assign bus.inst        = inst_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_result = done_result_q;
  assign bus.done_flags  = done_flags_q;
  assign bus.busy        = (state_q != IDLE) | ~empty;
  assign bus.occupancy   = count_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Testbench for alu_rf_sequencer. The bench plays the ALU + register file:
// opcode 0 = add, 1 = sub, 2 = and, 3 = xor; flags = {neg, carry/borrow, zero}.
module tb_alu_rf_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_rf_sequencer_if #(.AW(2)) bus();
  alu_rf_sequencer #(.DEPTH(4), .AW(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model with a bench-side preload port.
  logic [15:0] regs [16];
  logic        pl_en   = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (bus.regwrite) regs[bus.ra1] <= bus.result;
  end

  logic [16:0] s17;
  logic [15:0] opa, opb, alu_r;
  logic        cy;
  always_comb begin
    opa   = regs[bus.ra1];
    opb   = regs[bus.ra2];
    s17   = '0;
    cy    = 1'b0;
    alu_r = opa;
    case (bus.inst)
      4'h0: begin s17 = {1'b0, opa} + {1'b0, opb}; alu_r = s17[15:0]; cy = s17[16]; end
      4'h1: begin s17 = {1'b0, opa} - {1'b0, opb}; alu_r = s17[15:0]; cy = s17[16]; end
      4'h2: alu_r = opa & opb;
      4'h3: alu_r = opa ^ opb;
      default: alu_r = opa;
    endcase
    bus.result  = alu_r;
    bus.flagreg = {13'b0, alu_r[15], cy, (alu_r == 16'h0000)};
  end

  // Stream capture state
  int          got_n;
  logic [15:0] got_res [16];
  int          got_cyc [16];
  bit          saw_full, bad_ready;
  int          max_occ;

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents a command from a negedge and returns just after the accepting edge.
  task automatic push_one(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic wb, output bit ok);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ra1 = a; bus.cmd_ra2 = b; bus.cmd_wb = wb;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_one(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic wb, output logic [15:0] res, output logic [15:0] flg,
                         output bit seen);
    bit ok;
    push_one(op, a, b, wb, ok);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 1'b0; res = 'x; flg = 'x;
    for (int i = 0; i < 10; i++) begin
      if (bus.done_valid) begin seen = 1'b1; res = bus.done_result; flg = bus.done_flags; break; end
      @(negedge clk);
    end
    wait_idle(ok);
  endtask

  // Pushes n commands add(i, i+1, wb=0) as fast as cmd_ready allows and
  // records the done pulses.
  task automatic stream(input int n);
    int sent, waited;
    sent = 0; waited = 0; got_n = 0; saw_full = 0; bad_ready = 0; max_occ = 0;
    fork
      begin
        while (sent < n && waited < 200) begin
          @(negedge clk);
          bus.cmd_valid = 1'b1; bus.cmd_op = 4'h0; bus.cmd_wb = 1'b0;
          bus.cmd_ra1 = 4'(sent); bus.cmd_ra2 = 4'(sent + 1);
          if (bus.cmd_ready) sent++;
          waited++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
      end
      begin
        for (int m = 0; m < 300 && got_n < n; m++) begin
          @(negedge clk);
          if (bus.done_valid) begin
            got_res[got_n] = bus.done_result;
            got_cyc[got_n] = cyc;
            got_n++;
          end
          if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
          if (bus.occupancy == 3'd4 && !bus.cmd_ready) saw_full = 1'b1;
          if (bus.occupancy != 3'd4 && !bus.cmd_ready) bad_ready = 1'b1;
        end
      end
    join
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.regwrite, bus.ra1, bus.ra2, bus.inst, bus.done_valid, bus.busy, bus.occupancy} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rw=%0b ra1=%0d ra2=%0d inst=%0d dv=%0b busy=%0b occ=%0d, expected all 0",
        bus.regwrite, bus.ra1, bus.ra2, bus.inst, bus.done_valid, bus.busy, bus.occupancy);
    end
    checks++;
    if ({bus.done_result, bus.done_flags} !== 32'h0) begin
      errors++; $display("FAIL reset_done_data: got %h/%h expected 0/0", bus.done_result, bus.done_flags);
    end
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %0b expected 0", bus.cmd_ready); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0b expected 0", bus.cmd_ready); end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %0b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_add_wb;
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd3);
    @(negedge clk);
    bus.cmd_op = 4'h0; bus.cmd_ra1 = 4'd1; bus.cmd_ra2 = 4'd2; bus.cmd_wb = 1'b1; bus.cmd_valid = 1'b1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0b expected 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.occupancy, bus.regwrite} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL add_queued: got occ=%0d rw=%0b expected occ=1 rw=0", bus.occupancy, bus.regwrite);
    end
    @(negedge clk);
    checks++;
    if ({bus.ra1, bus.ra2, bus.inst, bus.regwrite} !== {4'd1, 4'd2, 4'd0, 1'b0}) begin
      errors++; $display("FAIL add_exec: got ra1=%0d ra2=%0d inst=%0d rw=%0b expected 1 2 0 0",
        bus.ra1, bus.ra2, bus.inst, bus.regwrite);
    end
    @(negedge clk);
    checks++;
    if ({bus.regwrite, bus.ra1, bus.done_valid} !== {1'b1, 4'd1, 1'b0}) begin
      errors++; $display("FAIL add_wb_cycle: got rw=%0b ra1=%0d dv=%0b expected 1 1 0", bus.regwrite, bus.ra1, bus.done_valid);
    end
    checks++;
    if (bus.done_result !== 16'd8) begin errors++; $display("FAIL add_capture: got %0d expected 8", bus.done_result); end
    @(negedge clk);
    checks++;
    if ({bus.done_valid, bus.regwrite, bus.ra1, bus.done_result, bus.done_flags} !== {1'b1, 1'b0, 4'd0, 16'd8, 16'd0}) begin
      errors++; $display("FAIL add_done: got dv=%0b rw=%0b ra1=%0d res=%0d flg=%h expected 1 0 0 8 0",
        bus.done_valid, bus.regwrite, bus.ra1, bus.done_result, bus.done_flags);
    end
    @(negedge clk);
    checks++;
    if ({bus.done_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL add_idle: got dv=%0b busy=%0b expected 0 0", bus.done_valid, bus.busy);
    end
    checks++;
    if (regs[1] !== 16'd8) begin errors++; $display("FAIL add_r1_written: got %0d expected 8", regs[1]); end
  endtask

  task automatic test_add_nowb;
    bit ok, saw_wr, seen;
    logic [15:0] dres;
    preload(4'd1, 16'd5);
    push_one(4'h0, 4'd1, 4'd2, 1'b0, ok);
    saw_wr = 1'b0; seen = 1'b0; dres = 'x;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.regwrite) saw_wr = 1'b1;
      if (bus.done_valid) begin seen = 1'b1; dres = bus.done_result; end
    end
    checks++;
    if (saw_wr !== 1'b0) begin errors++; $display("FAIL nowb_regwrite: got %0b expected 0", saw_wr); end
    checks++;
    if ({seen, dres} !== {1'b1, 16'd8}) begin
      errors++; $display("FAIL nowb_done: got seen=%0b res=%0d expected 1 8", seen, dres);
    end
    checks++;
    if (regs[1] !== 16'd5) begin errors++; $display("FAIL nowb_r1_kept: got %0d expected 5", regs[1]); end
  endtask

  task automatic test_flags;
    logic [15:0] res, flg;
    bit seen;
    preload(4'd3, 16'hFFFF);
    preload(4'd4, 16'h0001);
    run_one(4'h0, 4'd3, 4'd4, 1'b0, res, flg, seen);
    checks++;
    if ({seen, res, flg} !== {1'b1, 16'h0000, 16'h0003}) begin
      errors++; $display("FAIL add_carry_zero: got seen=%0b res=%h flg=%h expected 1 0000 0003", seen, res, flg);
    end
    preload(4'd5, 16'h0000);
    preload(4'd6, 16'h0001);
    run_one(4'h1, 4'd5, 4'd6, 1'b1, res, flg, seen);
    checks++;
    if ({seen, res, flg} !== {1'b1, 16'hFFFF, 16'h0006}) begin
      errors++; $display("FAIL sub_borrow: got seen=%0b res=%h flg=%h expected 1 ffff 0006", seen, res, flg);
    end
    checks++;
    if (regs[5] !== 16'hFFFF) begin errors++; $display("FAIL sub_writeback: got %h expected ffff", regs[5]); end
  endtask

  task automatic test_fifo_full;
    logic [15:0] exp7 [7] = '{16'd10, 16'd30, 16'd50, 16'd70, 16'd90, 16'd110, 16'd130};
    bit ok;
    for (int k = 0; k < 16; k++) preload(4'(k), 16'(k * 10));
    stream(7);
    checks++;
    if (got_n !== 7) begin errors++; $display("FAIL full_done_count: got %0d expected 7", got_n); end
    for (int i = 0; i < 7 && i < got_n; i++) begin
      checks++;
      if (got_res[i] !== exp7[i]) begin errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", i, got_res[i], exp7[i]); end
      if (i > 0) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] !== 3) begin
          errors++; $display("FAIL full_spacing[%0d]: got %0d expected 3", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    checks++;
    if ({saw_full, bad_ready} !== 2'b10) begin
      errors++; $display("FAIL full_ready: got saw_full=%0b bad_ready=%0b expected 1 0", saw_full, bad_ready);
    end
    checks++;
    if (max_occ !== 4) begin errors++; $display("FAIL full_max_occ: got %0d expected 4", max_occ); end
    wait_idle(ok);
  endtask

  task automatic test_wrap;
    logic [15:0] exp10 [10] = '{16'd10, 16'd30, 16'd50, 16'd70, 16'd90,
                                16'd110, 16'd130, 16'd150, 16'd170, 16'd190};
    bit ok;
    stream(10);
    checks++;
    if (got_n !== 10) begin errors++; $display("FAIL wrap_done_count: got %0d expected 10", got_n); end
    for (int i = 0; i < 10 && i < got_n; i++) begin
      checks++;
      if (got_res[i] !== exp10[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, got_res[i], exp10[i]); end
    end
    wait_idle(ok);
    checks++;
    if ({ok, bus.busy, bus.occupancy} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL wrap_drained: got idle=%0b busy=%0b occ=%0d expected 1 0 0", ok, bus.busy, bus.occupancy);
    end
  endtask

  task automatic test_reset_mid_wb;
    bit ok;
    int dones;
    bit was_busy;
    preload(4'd5, 16'd7);
    preload(4'd6, 16'd2);
    push_one(4'h0, 4'd5, 4'd6, 1'b1, ok);
    push_one(4'h0, 4'd6, 4'd5, 1'b0, ok);
    push_one(4'h0, 4'd5, 4'd5, 1'b0, ok);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.regwrite, bus.occupancy} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL rst_setup: got rw=%0b occ=%0d expected 1 2", bus.regwrite, bus.occupancy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.regwrite, bus.occupancy, bus.busy, bus.cmd_ready, bus.done_valid} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_immediate: got rw=%0b occ=%0d busy=%0b rdy=%0b dv=%0b expected 0 0 0 0 0",
        bus.regwrite, bus.occupancy, bus.busy, bus.cmd_ready, bus.done_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0; was_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_valid) dones++;
      if (bus.busy) was_busy = 1'b1;
    end
    checks++;
    if ({dones, was_busy} !== {32'd0, 1'b0}) begin
      errors++; $display("FAIL rst_no_replay: got dones=%0d busy_seen=%0b expected 0 0", dones, was_busy);
    end
    checks++;
    if (regs[5] !== 16'd7) begin errors++; $display("FAIL rst_no_write: got %0d expected 7", regs[5]); end
  endtask

  task automatic test_push_pop_same;
    bit ok, found;
    push_one(4'h0, 4'd1, 4'd2, 1'b0, ok);
    push_one(4'h0, 4'd2, 4'd3, 1'b0, ok);
    push_one(4'h0, 4'd3, 4'd4, 1'b0, ok);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done_valid && bus.occupancy == 3'd2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL pp_setup: got found=%0b expected 1", found); end
    bus.cmd_op = 4'h0; bus.cmd_ra1 = 4'd4; bus.cmd_ra2 = 4'd5; bus.cmd_wb = 1'b0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL pp_occupancy: got %0d expected 2", bus.occupancy); end
    wait_idle(ok);
    checks++;
    if ({ok, bus.occupancy} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL pp_drain: got idle=%0b occ=%0d expected 1 0", ok, bus.occupancy);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ra1   = '0;
    bus.cmd_ra2   = '0;
    bus.cmd_wb    = 1'b0;
    test_reset;
    test_add_wb;
    test_add_nowb;
    test_flags;
    test_fifo_full;
    test_wrap;
    test_reset_mid_wb;
    test_push_pop_same;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
